data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter WORD_BITWIDTH, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter DEPTH_BITWIDTH, default 10, meaning log2 of the word depth, 1024 words by default.
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning cycles from request accept to response; the legal range is 1..15.
REQ-004 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  memRead  in  1  read request.
  memWrite  in  1  write request.
  address  in  WORD_BITWIDTH  byte address from the MEM stage.
  memWriteData  in  WORD_BITWIDTH  store data.
  byteEnable  in  WORD_BITWIDTH/8  per-byte write enable.
  memReadData  out  WORD_BITWIDTH  load data, valid when memReady=1.
  memReady  out  1  one-cycle response strobe.
  misaligned  out  1  error flag, valid when memReady=1.
  busy  out  1  high from request accept until the response cycle, inclusive; the pipeline stalls on it.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-006 In IDLE, memRead|memWrite SHALL be accepted on a rising edge and SHALL capture address, data, byteEnable and the request type.
REQ-007 On accept, the FSM SHALL go to WAIT when LATENCY>1 and to RESP when LATENCY=1; the latency counter SHALL load LATENCY-1.
REQ-008 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP when the counter reaches 1.
REQ-009 memReady SHALL be high for exactly one cycle, in RESP, exactly LATENCY cycles after the accept edge; RESP SHALL always return to IDLE.
REQ-010 Requests presented outside IDLE SHALL be ignored and not queued; the requester SHALL hold them until memReady.
REQ-011 The word index SHALL be address[DEPTH_BITWIDTH+1:2]; upper address bits SHALL be ignored, so accesses wrap modulo the depth.
REQ-012 Writes SHALL update only the bytes with byteEnable=1, at the RESP edge.
REQ-013 With memRead and memWrite both high, the access SHALL be a write, and memReadData SHALL return the word contents before the write.
REQ-014 A pure write SHALL return memReadData = 0.
REQ-015 memReadData SHALL hold its value outside RESP and change only at the RESP entry edge.
REQ-016 busy SHALL be combinational and equal to (state!=IDLE).

Reset
REQ-017 While rst_n=0, the state SHALL be IDLE, and memReady, misaligned, busy and memReadData SHALL be 0.
REQ-018 Reset asserted mid-transaction SHALL abort it: no write is committed and no memReady is issued.
REQ-019 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-020 Macro DATA_MEM_MISALIGN_CHECK_EN SHALL control alignment checking.
REQ-021 With DATA_MEM_MISALIGN_CHECK_EN defined, an access with address[1:0]!=0 SHALL complete with normal timing, misaligned=1 and memReadData=0, and SHALL suppress the write.
REQ-022 Without DATA_MEM_MISALIGN_CHECK_EN, address[1:0] SHALL be ignored and misaligned SHALL be tied to 0.

Structure
REQ-023 Package data_mem_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), the counter width constant (4) and the default parameter constants.
REQ-024 Sub-module data_mem_array SHALL implement the storage: a synchronous read-before-write single-port array with byte-enable writes. The FSM, counter and capture registers SHALL stay in data_mem_resp.

Verification
REQ-025 Reset then idle: rst_n low 3 cycles, then high -> memReady=0, busy=0, memReadData=0.
REQ-026 Write then read, LATENCY=2: write 0xDEADBEEF at 0x10, byteEnable=4'hF -> memReady 2 cycles after accept. Read at 0x10 -> memReadData=0xDEADBEEF.
REQ-027 Byte enable and wrap: write 0x000000AA at 0x1010, byteEnable=4'h1, over 0x11223344 at 0x10 -> read at 0x10 returns 0x112233AA.
REQ-028 Simultaneous read/write: memRead=memWrite=1, data 0x55 at 0x20 holding 0x77 -> memReadData=0x77. A following read returns 0x55.
REQ-029 Misaligned, macro on: write at 0x22 -> misaligned=1, memReadData=0, memory unchanged.
REQ-030 Reset mid-operation: assert rst_n low in WAIT of a write -> no memReady, state IDLE, target word unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg
// Shared definitions for the data memory responder: FSM state encoding,
// latency counter width and default parameter values.
package data_mem_pkg;

  localparam int CNT_W              = 4;
  localparam int DEF_WORD_BITWIDTH  = 32;
  localparam int DEF_DEPTH_BITWIDTH = 10;
  localparam int DEF_LATENCY        = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array
// Single-port synchronous storage with byte-enable writes. A read and a
// write on the same edge return the pre-write contents. The read data
// register is cleared by reset; the storage itself is never cleared.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   async active-low reset (read data register only)
//   en       in   perform an access on this edge
//   we       in   commit the write bytes selected by be
//   zero_rd  in   load zero into the read data register instead of storage
//   idx      in   word index
//   wdata    in   write data
//   be       in   per-byte write enable
//   rdata    out  registered read data, updated only on enabled edges
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int WORD_BITWIDTH  = DEF_WORD_BITWIDTH,
  parameter int DEPTH_BITWIDTH = DEF_DEPTH_BITWIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       we,
  input  logic                       zero_rd,
  input  logic [DEPTH_BITWIDTH-1:0]  idx,
  input  logic [WORD_BITWIDTH-1:0]   wdata,
  input  logic [WORD_BITWIDTH/8-1:0] be,
  output logic [WORD_BITWIDTH-1:0]   rdata
);

  localparam int NBYTES = WORD_BITWIDTH / 8;

  logic [WORD_BITWIDTH-1:0] mem [2**DEPTH_BITWIDTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Non-blocking read of the same word yields the contents before the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= zero_rd ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp
// Fixed-latency data memory responder for the MEM stage. A read or write
// request accepted in IDLE is answered with a one-cycle memReady strobe
// LATENCY cycles later; busy stalls the pipeline meanwhile. The storage
// access (read-before-write, byte-enabled) happens on the edge that enters
// RESP, so an access aborted by reset never touches memory.
// LATENCY must be in 1..15.
//
// Optional feature: define DATA_MEM_MISALIGN_CHECK_EN to flag accesses
// with address[1:0]!=0 (write suppressed, zero read data).
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   async active-low reset
//   memRead       in   read request
//   memWrite      in   write request (wins when both are set)
//   address       in   byte address
//   memWriteData  in   store data
//   byteEnable    in   per-byte write enable
//   memReadData   out  load data, valid with memReady
//   memReady      out  one-cycle response strobe
//   misaligned    out  alignment error, valid with memReady
//   busy          out  high from accept through the response cycle
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | latency counter running
// RESP  | memReady cycle, returns to IDLE
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int WORD_BITWIDTH  = DEF_WORD_BITWIDTH,
  parameter int DEPTH_BITWIDTH = DEF_DEPTH_BITWIDTH,
  parameter int LATENCY        = DEF_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       memRead,
  input  logic                       memWrite,
  input  logic [WORD_BITWIDTH-1:0]   address,
  input  logic [WORD_BITWIDTH-1:0]   memWriteData,
  input  logic [WORD_BITWIDTH/8-1:0] byteEnable,
  output logic [WORD_BITWIDTH-1:0]   memReadData,
  output logic                       memReady,
  output logic                       misaligned,
  output logic                       busy
);

  localparam int AW = DEPTH_BITWIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       armed_q;
  logic                       accept;
  logic                       go_resp;

  logic [AW-1:0]              addr_q;
  logic [WORD_BITWIDTH-1:0]   wdata_q;
  logic [WORD_BITWIDTH/8-1:0] be_q;
  logic                       rd_q, wr_q;

  logic [AW-1:0]              addr_sel;
  logic [WORD_BITWIDTH-1:0]   wdata_sel;
  logic [WORD_BITWIDTH/8-1:0] be_sel;
  logic                       rd_sel, wr_sel, mis_sel;

  // Upper address bits select nothing: accesses wrap modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[WORD_BITWIDTH-1:AW], address[1:0]};

  // Blocks accepts on the first edge after reset release, so an edge seen
  // while reset is still asserted can never start (or, with LATENCY=1,
  // commit) an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  assign accept = (state_q == IDLE) && (memRead || memWrite) && armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= address[AW-1:0];
      wdata_q <= memWriteData;
      be_q    <= byteEnable;
      rd_q    <= memRead;
      wr_q    <= memWrite;
    end
  end

  // With LATENCY=1 the access happens on the accept edge itself, before the
  // capture registers hold the request, so take the live inputs in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      addr_sel  = address[AW-1:0];
      wdata_sel = memWriteData;
      be_sel    = byteEnable;
      rd_sel    = memRead;
      wr_sel    = memWrite;
    end else begin
      addr_sel  = addr_q;
      wdata_sel = wdata_q;
      be_sel    = be_q;
      rd_sel    = rd_q;
      wr_sel    = wr_q;
    end
  end

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic mis_q;

  assign mis_sel = |addr_sel[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mis_q <= 1'b0;
    else if (go_resp) mis_q <= mis_sel;
  end

  assign misaligned = mis_q && (state_q == RESP);
`else
  assign mis_sel    = 1'b0;
  assign misaligned = 1'b0;
`endif

  // A pure write returns zero; read+write returns the pre-write word.
  data_mem_array #(
    .WORD_BITWIDTH  (WORD_BITWIDTH),
    .DEPTH_BITWIDTH (DEPTH_BITWIDTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (go_resp),
    .we      (wr_sel && !mis_sel),
    .zero_rd (!rd_sel || mis_sel),
    .idx     (addr_sel[AW-1:2]),
    .wdata   (wdata_sel),
    .be      (be_sel),
    .rdata   (memReadData)
  );

  assign memReady = (state_q == RESP);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] memWriteData;
  logic [3:0]  byteEnable;
  logic [31:0] memReadData;
  logic        memReady;
  logic        misaligned;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  data_mem_resp #(
    .WORD_BITWIDTH  (32),
    .DEPTH_BITWIDTH (10),
    .LATENCY        (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .address      (address),
    .memWriteData (memWriteData),
    .byteEnable   (byteEnable),
    .memReadData  (memReadData),
    .memReady     (memReady),
    .misaligned   (misaligned),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at a negedge, hold it until memReady is seen, then
  // drop it. lat counts edges from the accept edge to the memReady sample,
  // -1 when no response arrives within the budget.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output logic [31:0] rdata, output logic mis, output int lat);
    @(negedge clk);
    memRead = rd; memWrite = wr; address = addr; memWriteData = data; byteEnable = be;
    @(posedge clk);
    lat = -1;
    rdata = 'x;
    mis = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (memReady) begin
        lat = i;
        rdata = memReadData;
        mis = misaligned;
        break;
      end
    end
    memRead = 1'b0; memWrite = 1'b0; address = '0; memWriteData = '0; byteEnable = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (memReady !== 1'b0 || busy !== 1'b0 || memReadData !== 32'h0 || misaligned !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: ready=%b busy=%b rdata=%h mis=%b, required 0 0 00000000 0",
               memReady, busy, memReadData, misaligned);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (memReady !== 1'b0 || busy !== 1'b0 || memReadData !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_idle: ready=%b busy=%b rdata=%h, required 0 0 00000000",
               memReady, busy, memReadData);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        mis;
    int          lat;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, mis, lat);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL write_latency: got %0d, required 2", lat);
    end
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL pure_write_rdata: got %h, required 00000000", rd);
    end
    @(negedge clk);
    tests_run++;
    if (memReady !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_one_cycle: ready=%b busy=%b, required 0 0", memReady, busy);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL read_latency: got %0d, required 2", lat);
    end
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL read_back: got %h, required deadbeef", rd);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (memReadData !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rdata_hold: got %h, required deadbeef", memReadData);
    end
  endtask

  task automatic test_byte_wrap();
    logic [31:0] rd;
    logic        mis;
    int          lat;
    access(1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF, rd, mis, lat);
    access(1'b0, 1'b1, 32'h1010, 32'h000000AA, 4'h1, rd, mis, lat);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (rd !== 32'h112233AA) begin
      tests_failed++;
      $display("FAIL byte_wrap: got %h, required 112233aa", rd);
    end
    access(1'b0, 1'b1, 32'h10, 32'hFFEEDDCC, 4'hA, rd, mis, lat);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (rd !== 32'hFF22DDAA) begin
      tests_failed++;
      $display("FAIL byte_mask_a: got %h, required ff22ddaa", rd);
    end
  endtask

  task automatic test_read_write();
    logic [31:0] rd;
    logic        mis;
    int          lat;
    access(1'b0, 1'b1, 32'h20, 32'h77, 4'hF, rd, mis, lat);
    access(1'b1, 1'b1, 32'h20, 32'h55, 4'hF, rd, mis, lat);
    tests_run++;
    if (rd !== 32'h77) begin
      tests_failed++;
      $display("FAIL rw_old_data: got %h, required 00000077", rd);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (rd !== 32'h55) begin
      tests_failed++;
      $display("FAIL rw_new_data: got %h, required 00000055", rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic        mis;
    int          lat;
    access(1'b0, 1'b1, 32'h22, 32'h99, 4'hF, rd, mis, lat);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    tests_run++;
    if (mis !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      tests_failed++;
      $display("FAIL misalign_flag: mis=%b rdata=%h lat=%0d, required 1 00000000 2", mis, rd, lat);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (rd !== 32'h55 || mis !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_unchanged: rdata=%h mis=%b, required 00000055 0", rd, mis);
    end
`else
    tests_run++;
    if (mis !== 1'b0 || lat !== 2) begin
      tests_failed++;
      $display("FAIL misalign_off_flag: mis=%b lat=%0d, required 0 2", mis, lat);
    end
    access(1'b1, 1'b0, 32'h23, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (rd !== 32'h99 || mis !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_off_data: rdata=%h mis=%b, required 00000099 0", rd, mis);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        mis;
    int          lat;
    access(1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, rd, mis, lat);
    @(negedge clk);
    memWrite = 1'b1; address = 32'h30; memWriteData = 32'hCAFEF00D; byteEnable = 4'hF;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || memReady !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_in_wait: busy=%b ready=%b, required 1 0", busy, memReady);
    end
    rst_n = 1'b0;
    memWrite = 1'b0; address = '0; memWriteData = '0; byteEnable = '0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || memReady !== 1'b0 || memReadData !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_abort: busy=%b ready=%b rdata=%h, required 0 0 00000000",
               busy, memReady, memReadData);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (memReady !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_no_ready: cycle %0d ready=%b busy=%b, required 0 0", i, memReady, busy);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (rd !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL mid_word_kept: got %h, required 12345678", rd);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, mis, lat);
    tests_run++;
    if (rd !== 32'hFF22DDAA) begin
      tests_failed++;
      $display("FAIL mem_survives_reset: got %h, required ff22ddaa", rd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    address = '0;
    memWriteData = '0;
    byteEnable = '0;
    test_reset();
    test_write_read();
    test_byte_wrap();
    test_read_write();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
